// File: rtl/dadda_mult_pkg.sv
// Shared elaboration helpers for the pipelined Dadda multiplier: reduction heights,
// stage count, Baugh-Wooley correction constant and the adder cells used by the tree.
package dadda_mult_pkg;

  // Dadda height sequence, k = 1 -> 2, 3, 4, 6, 9, 13, 19, 28, 42 ...
  function automatic int dadda_height(input int k);
    int d;
    d = 2;
    for (int i = 1; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  // Number of reduction stages needed to bring a WIDTH-high matrix down to two rows.
  function automatic int dadda_stages(input int width);
    int n;
    n = 0;
    while (dadda_height(n + 1) < width) n++;
    return n;
  endfunction

  // Baugh-Wooley correction bits: one in column WIDTH, one in column 2*WIDTH-1.
  function automatic logic [63:0] bw_const(input int width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

  // Full adder {carry, sum}; self-dual, so it serves unchanged on inverted operands.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Half adder on inverted operands returning inverted {carry, sum}.
  function automatic logic [1:0] half_adder_io(input logic xn, input logic yn);
    return {xn | yn, ~(xn ^ yn)};
  endfunction

endpackage

// File: rtl/dadda_mult_pipe_if.sv
// Operand/result handshake bundle for dadda_mult_pipe.
// With DADDA_MULT_CSA_OUT_EN defined it also carries the carry-save rows result_a/result_b.
interface dadda_mult_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     operand_a;
  logic [WIDTH-1:0]     operand_b;
  logic                 op_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result_final;
  logic [TAG_W-1:0]     out_tag;
`ifdef DADDA_MULT_CSA_OUT_EN
  logic [2*WIDTH-1:0]   result_a;
  logic [2*WIDTH-1:0]   result_b;
`endif

  modport master (
`ifdef DADDA_MULT_CSA_OUT_EN
    input  result_a, result_b,
`endif
    output in_valid, operand_a, operand_b, op_signed, in_tag, out_ready,
    input  in_ready, out_valid, result_final, out_tag
  );

  modport slave (
`ifdef DADDA_MULT_CSA_OUT_EN
    output result_a, result_b,
`endif
    input  in_valid, operand_a, operand_b, op_signed, in_tag, out_ready,
    output in_ready, out_valid, result_final, out_tag
  );
endinterface

// File: rtl/dadda_csa_tree.sv
// Combinational Dadda reduction of the (Baugh-Wooley) partial-product matrix to two rows.
// The matrix is held in inverted (NAND) polarity throughout and restored at the outputs.
module dadda_csa_tree
  import dadda_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic               op_signed,
  output logic [2*WIDTH-1:0] row_a,
  output logic [2*WIDTH-1:0] row_b
);
  localparam int          ProdW   = 2 * WIDTH;
  localparam int          HMax    = WIDTH + 2;
  localparam int          Stages  = dadda_stages(WIDTH);
  localparam logic [63:0] BwConst = bw_const(WIDTH);

  logic [HMax-1:0] mat_n [ProdW];
  logic [HMax-1:0] nxt_n [ProdW];
  int              hgt   [ProdW];
  int              nhgt  [ProdW];
  int              idx;
  logic [1:0]      cs;

  always_comb begin
    idx = 0;
    cs  = '0;
    for (int c = 0; c < ProdW; c++) begin
      mat_n[c] = '1;
      nxt_n[c] = '1;
      hgt[c]   = 0;
      nhgt[c]  = 0;
    end
    // Sign-row terms (exactly one index at WIDTH-1) flip when signed; stored inverted.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        mat_n[i+j][hgt[i+j]] = ~((operand_a[j] & operand_b[i]) ^
                                 (op_signed & ((i == WIDTH - 1) != (j == WIDTH - 1))));
        hgt[i+j]++;
      end
    end
    for (int c = 0; c < ProdW; c++) begin
      if (BwConst[c]) begin
        mat_n[c][hgt[c]] = ~op_signed;
        hgt[c]++;
      end
    end
    for (int s = Stages; s >= 1; s--) begin
      for (int c = 0; c < ProdW; c++) begin
        nxt_n[c] = '1;
        nhgt[c]  = 0;
      end
      for (int c = 0; c < ProdW; c++) begin
        idx = 0;
        for (int k = 0; k < HMax; k++) begin
          if (hgt[c] - idx + nhgt[c] > dadda_height(s)) begin
            if (hgt[c] - idx + nhgt[c] == dadda_height(s) + 1) begin
              cs  = half_adder_io(mat_n[c][idx], mat_n[c][idx+1]);
              idx = idx + 2;
            end else begin
              cs  = full_adder(mat_n[c][idx], mat_n[c][idx+1], mat_n[c][idx+2]);
              idx = idx + 3;
            end
            nxt_n[c][nhgt[c]] = cs[0];
            nhgt[c]++;
            if (c + 1 < ProdW) begin
              nxt_n[c+1][nhgt[c+1]] = cs[1];
              nhgt[c+1]++;
            end
          end
        end
        for (int k = 0; k < HMax; k++) begin
          if (idx + k < hgt[c]) begin
            nxt_n[c][nhgt[c]] = mat_n[c][idx+k];
            nhgt[c]++;
          end
        end
      end
      for (int c = 0; c < ProdW; c++) begin
        mat_n[c] = nxt_n[c];
        hgt[c]   = nhgt[c];
      end
    end
    for (int c = 0; c < ProdW; c++) begin
      row_a[c] = (hgt[c] > 0) ? ~mat_n[c][0] : 1'b0;
      row_b[c] = (hgt[c] > 1) ? ~mat_n[c][1] : 1'b0;
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Two-stage pipelined Dadda multiplier: CSA tree into stage 1, carry-propagate add into stage 2.
// Define DADDA_MULT_CSA_OUT_EN to also export the carry-save rows aligned with result_final.
module dadda_mult_pipe
  import dadda_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  dadda_mult_pipe_if.slave bus
);
  localparam int unsigned PROD_W = 2 * WIDTH;

  logic [PROD_W-1:0] row_a, row_b;
  logic              s1_load, s2_load;

  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] s1_row_a_q, s1_row_a_d;
  logic [PROD_W-1:0] s1_row_b_q, s1_row_b_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
`ifdef DADDA_MULT_CSA_OUT_EN
  logic [PROD_W-1:0] s2_row_a_q, s2_row_a_d;
  logic [PROD_W-1:0] s2_row_b_q, s2_row_b_d;
`endif

  dadda_csa_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .operand_a(bus.operand_a),
    .operand_b(bus.operand_b),
    .op_signed(bus.op_signed),
    .row_a    (row_a),
    .row_b    (row_b)
  );

  always_comb begin
    s2_load     = !s2_valid_q || bus.out_ready;
    s1_load     = !s1_valid_q || s2_load;
    s1_valid_d  = s1_valid_q;
    s1_row_a_d  = s1_row_a_q;
    s1_row_b_d  = s1_row_b_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
`ifdef DADDA_MULT_CSA_OUT_EN
    s2_row_a_d  = s2_row_a_q;
    s2_row_b_d  = s2_row_b_q;
`endif
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_row_a_d = row_a;
        s1_row_b_d = row_b;
        s1_tag_d   = bus.in_tag;
      end
    end
    // An empty stage 1 moving forward leaves a bubble; stale data behind out_valid=0 is harmless.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = s1_row_a_q + s1_row_b_q;
        s2_tag_d    = s1_tag_q;
`ifdef DADDA_MULT_CSA_OUT_EN
        s2_row_a_d  = s1_row_a_q;
        s2_row_b_d  = s1_row_b_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_row_a_q  <= '0;
      s1_row_b_q  <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
`ifdef DADDA_MULT_CSA_OUT_EN
      s2_row_a_q  <= '0;
      s2_row_b_q  <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_row_a_q  <= s1_row_a_d;
      s1_row_b_q  <= s1_row_b_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
`ifdef DADDA_MULT_CSA_OUT_EN
      s2_row_a_q  <= s2_row_a_d;
      s2_row_b_q  <= s2_row_b_d;
`endif
    end
  end

  assign bus.in_ready     = s1_load;
  assign bus.out_valid    = s2_valid_q;
  assign bus.result_final = s2_result_q;
  assign bus.out_tag      = s2_tag_q;
`ifdef DADDA_MULT_CSA_OUT_EN
  assign bus.result_a     = s2_row_a_q;
  assign bus.result_b     = s2_row_b_q;
`endif

endmodule
